// File: rtl/cache_sim_pkg.sv
// Shared types and constants for the cache trace player and its cache model.
package cache_sim_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_READ,
    S_WRITE,
    S_FINISH
  } drv_state_e;

  localparam int OFFSET_LSB = 0;
  localparam int INDEX_LSB  = 1;
  localparam int INDEX_W    = 4;
  localparam int TAG_LSB    = 5;

  localparam logic PHASE_READ  = 1'b0;
  localparam logic PHASE_WRITE = 1'b1;

endpackage

// File: rtl/cache_trace_driver_if.sv
// Driver <-> cache hit-check bus: reference address, two-phase state, hit return.
interface cache_trace_driver_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] addr_out;
  logic              state_out;
  logic              hit_in;

  modport master (output addr_out, output state_out, input hit_in);
  modport slave  (input addr_out, input state_out, output hit_in);
endinterface

// File: rtl/cache_trace_driver_ram.sv
// Trace storage: synchronous write, registered read with a resettable output register.
module trace_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;

  // Output only moves on a read, so it doubles as the held cache address.
  always_ff @(posedge clk or posedge rst)
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];

  assign o_rdata = r_rdata;
endmodule

// File: rtl/cache_trace_driver.sv
// Replays a stored reference trace into a cache and gathers hit/miss statistics.
// Optional CACHE_DRV_MISS_RUN_EN builds the longest-miss-run tracker.
module cache_trace_driver
  import cache_sim_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int TRACE_DEPTH   = 1024,
  parameter int PTR_W         = 10,
  parameter int CNT_W         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PTR_W:0]       trace_len,
  input  logic                 trace_wr_en,
  input  logic [PTR_W-1:0]     trace_wr_addr,
  input  logic [ADDR_W-1:0]    trace_wr_data,
  cache_trace_driver_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count,
  output logic [CNT_W-1:0]     ref_count,
  output logic [CNT_W-1:0]     miss_run_max
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  drv_state_e         r_state, w_next;
  logic [PTR_W:0]     r_len, w_len, w_ptr_nx;
  logic [PTR_W-1:0]   r_ptr;
  logic [SW-1:0]      r_settle;
  logic [CNT_W-1:0]   r_hit, r_miss, r_ref;
  logic               r_busy, r_done;
  logic               w_accept, w_last_settle, w_sample, w_last_ref;
  logic               w_ram_we, w_ram_re;
  logic [PTR_W-1:0]   w_ram_addr;
  logic [ADDR_W-1:0]  w_rdata;

  assign w_len         = (trace_len > (PTR_W+1)'(TRACE_DEPTH)) ? (PTR_W+1)'(TRACE_DEPTH) : trace_len;
  assign w_accept      = start && (r_state == S_IDLE);
  assign w_last_settle = (r_settle == SW'(SETTLE_CYCLES - 1));
  assign w_sample      = (r_state == S_WRITE) && w_last_settle;
  assign w_ptr_nx      = {1'b0, r_ptr} + (PTR_W+1)'(1);
  assign w_last_ref    = (w_ptr_nx == r_len);

  // Loads are only accepted outside a replay; the port is shared with the fetch.
  assign w_ram_we   = trace_wr_en && ((r_state == S_IDLE) || (r_state == S_FINISH));
  assign w_ram_re   = (r_state == S_FETCH);
  assign w_ram_addr = w_ram_re ? r_ptr : trace_wr_addr;

  trace_ram #(.DEPTH(TRACE_DEPTH), .AW(PTR_W), .DW(ADDR_W)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (trace_wr_data),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = (w_len == '0) ? S_FINISH : S_FETCH;
      S_FETCH:  w_next = S_READ;
      S_READ:   w_next = S_WRITE;
      S_WRITE:  if (w_sample) w_next = w_last_ref ? S_FINISH : S_FETCH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len <= '0; r_ptr <= '0; r_settle <= '0;
      r_hit <= '0; r_miss <= '0; r_ref <= '0;
      r_busy <= 1'b0; r_done <= 1'b0;
    end else begin
      if (w_accept) begin
        r_len  <= w_len;
        r_ptr  <= '0;
        r_hit  <= '0;
        r_miss <= '0;
        r_ref  <= '0;
        r_done <= 1'b0;
        r_busy <= (w_len != '0);
      end
      if (r_state == S_READ)
        r_settle <= '0;
      else if ((r_state == S_WRITE) && !w_last_settle)
        r_settle <= r_settle + SW'(1);
      if (w_sample) begin
        r_ptr <= r_ptr + PTR_W'(1);
        // A saturated ref_count freezes hit/miss too, keeping hit+miss == ref.
        if (r_ref != '1) begin
          r_ref <= r_ref + CNT_W'(1);
          if (bus.hit_in) r_hit  <= r_hit + CNT_W'(1);
          else            r_miss <= r_miss + CNT_W'(1);
        end
        if (w_last_ref) r_busy <= 1'b0;
      end
      if (r_state == S_FINISH) r_done <= 1'b1;
    end
  end

`ifdef CACHE_DRV_MISS_RUN_EN
  logic [CNT_W-1:0] r_run, r_run_max, w_run_nx;

  assign w_run_nx = bus.hit_in ? '0 : ((r_run == '1) ? r_run : r_run + CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run <= '0; r_run_max <= '0;
    end else if (w_accept) begin
      r_run <= '0; r_run_max <= '0;
    end else if (w_sample) begin
      r_run <= w_run_nx;
      if (w_run_nx > r_run_max) r_run_max <= w_run_nx;
    end
  end

  assign miss_run_max = r_run_max;
`else
  assign miss_run_max = '0;
`endif

  assign bus.addr_out  = w_rdata;
  assign bus.state_out = (r_state == S_WRITE) ? PHASE_WRITE : PHASE_READ;
  assign busy       = r_busy;
  assign done       = r_done;
  assign hit_count  = r_hit;
  assign miss_count = r_miss;
  assign ref_count  = r_ref;
endmodule

// File: tb/tb_cache_trace_driver.sv
// Scoreboard bench: each replay pushes its expected statistics, a monitor checks them on done.
module tb_cache_trace_driver;
  localparam int ADDR_W = 32, DEPTH = 1024, PTR_W = 10, CNT_W = 32, S = 1;

  logic clk = 1'b0;
  logic rst, start, wr_en, flush;
  logic [PTR_W:0]    tlen;
  logic [PTR_W-1:0]  wa;
  logic [ADDR_W-1:0] wd;
  logic              busy, done;
  logic [CNT_W-1:0]  hitc, missc, refc, runmax;
  int cyc = 0;
  int npass = 0, ntot = 0;

  cache_trace_driver_if #(.ADDR_W(ADDR_W)) bus ();

  cache_trace_driver #(.ADDR_W(ADDR_W), .TRACE_DEPTH(DEPTH), .PTR_W(PTR_W),
                       .CNT_W(CNT_W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .trace_len(tlen),
    .trace_wr_en(wr_en), .trace_wr_addr(wa), .trace_wr_data(wd),
    .bus(bus), .busy(busy), .done(done),
    .hit_count(hitc), .miss_count(missc), .ref_count(refc), .miss_run_max(runmax)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Direct-mapped cache model: 16 sets, index addr[4:1], tag addr[31:5].
  logic [15:0] cvalid;
  logic [26:0] ctag [16];
  logic        chk_ph, rhit;
  wire  [3:0]  cidx   = bus.addr_out[4:1];
  wire  [26:0] ctg    = bus.addr_out[31:5];
  wire         cmatch = cvalid[cidx] && (ctag[cidx] == ctg);

  always @(posedge clk) begin
    if (flush) begin
      cvalid <= '0; chk_ph <= 1'b0; rhit <= 1'b0;
    end else if (bus.state_out) begin
      if (!chk_ph) begin
        rhit <= cmatch; cvalid[cidx] <= 1'b1; ctag[cidx] <= ctg; chk_ph <= 1'b1;
      end
    end else chk_ph <= 1'b0;
  end
  assign bus.hit_in = bus.state_out && (chk_ph ? rhit : cmatch);

  typedef struct {
    int hits, misses, refs, rmax, lat, st1, t0;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int em(input int x);
`ifdef CACHE_DRV_MISS_RUN_EN
    return x;
`else
    return 0 * x;
`endif
  endfunction

  function automatic exp_t mk(input int h, input int m, input int rm, input int len);
    exp_t e;
    e.hits = h; e.misses = m; e.refs = h + m; e.rmax = em(rm);
    e.lat = len * (2 + S) + 2; e.st1 = len * S; e.t0 = 0;
    return e;
  endfunction

  // Monitor: counts check-phase cycles per replay, compares on each rising done.
  int  st1 = 0;
  logic pdone = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (start && !busy) st1 = 0;
    else if (bus.state_out) st1++;
    if (done && !pdone) begin
      if (q.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_done: got done expected none");
      end else begin
        e = q.pop_front();
        chk("hit_count", hitc, e.hits);
        chk("miss_count", missc, e.misses);
        chk("ref_count", refc, e.refs);
        chk("miss_run_max", runmax, e.rmax);
        chk("latency", cyc - e.t0, e.lat);
        chk("write_phases", st1, e.st1);
        chk("invariant", hitc + missc, refc);
      end
    end
    pdone = done;
  end

  // All tasks enter and leave one time unit after a rising edge.
  task automatic wr(input int idx, input logic [31:0] d);
    wr_en = 1'b1; wa = PTR_W'(idx); wd = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic launch(input int len, input exp_t e, input bit push);
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    e.t0 = cyc;
    if (push) q.push_back(e);
    tlen = (PTR_W+1)'(len); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20000) begin @(posedge clk); #1; n++; end
    if (!done) begin ntot++; $display("FAIL done_timeout: got done=0 expected done=1"); end
    @(posedge clk); #1;
  endtask

  task automatic wait_ref(input int r, input bit in_write);
    int n = 0;
    while (!(refc == CNT_W'(r) && (!in_write || bus.state_out)) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin ntot++; $display("FAIL ref_wait_timeout: got ref=%0d expected %0d", refc, r); end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, bus.addr_out, 0);
    chk({tag, "_state"}, bus.state_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_hit"}, hitc, 0);
    chk({tag, "_miss"}, missc, 0);
    chk({tag, "_ref"}, refc, 0);
    chk({tag, "_runmax"}, runmax, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr_en = 1'b0; flush = 1'b1; tlen = '0; wa = '0; wd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0; flush = 1'b0;
    @(posedge clk); #1;

    // Repeated address: first misses, second hits.
    wr(0, 32'h40); wr(1, 32'h40);
    launch(2, mk(1, 1, 1, 2), 1'b1); wait_done();

    // Empty replay.
    launch(0, mk(0, 0, 0, 0), 1'b1); wait_done();

    // Eight distinct tags into set 3.
    for (int t = 0; t < 8; t++) wr(t, (t << 5) | 32'h6);
    launch(8, mk(0, 8, 8, 8), 1'b1); wait_done();

    // Reset mid-replay during entry 5's check phase, then full replay.
    for (int i = 0; i < 10; i++) wr(i, (i % 5) << 1);
    launch(10, mk(0, 0, 0, 0), 1'b0);
    wait_ref(5, 1'b1);
    rst = 1'b1; #1;
    chk_zero("midrst");
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    launch(10, mk(5, 5, 5, 10), 1'b1); wait_done();

    // start and trace writes while busy are ignored.
    wr(0, 32'h0); wr(1, 32'h2); wr(2, 32'h0); wr(3, 32'h2); wr(4, 32'h20); wr(5, 32'h0);
    launch(6, mk(2, 4, 2, 6), 1'b1);
    wait_ref(2, 1'b0);
    start = 1'b1; wr_en = 1'b1; wa = PTR_W'(2); wd = 32'hFFFF_FFE0;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    wait_done();
    launch(6, mk(2, 4, 2, 6), 1'b1); wait_done();

    // Over-long trace_len clamps to the full depth.
    for (int i = 0; i < DEPTH; i++) wr(i, i << 5);
    launch(DEPTH + 5, mk(0, DEPTH, DEPTH, DEPTH), 1'b1); wait_done();

    repeat (3) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      ntot++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/cache_trace_driver.md
Name: cache_trace_driver

Overview:
Initiator side of the cache hit-check interface. It replays a stored memory-reference trace into a cache model one address at a time and drives the two-phase `state` signal (0 = read/enable, 1 = write/check). It samples the cache's `hit` output and accumulates hit, miss and reference statistics. It sits between the testbench or host loader and the `cache` instance, turning the simulator into a free-running clocked trace player.

Parameters:
ADDR_W, 32, width of a memory reference and of addr_out
TRACE_DEPTH, 1024, number of trace entries held in internal trace RAM (power of two)
PTR_W, 10, log2(TRACE_DEPTH); width of trace pointers and trace_len
CNT_W, 32, width of hit/miss/reference counters
SETTLE_CYCLES, 1, cycles state_out is held at 1 before hit_in is sampled (minimum 1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begin replay from entry 0
trace_len  in  PTR_W+1  number of entries to replay; captured on accepted start
trace_wr_en  in  1  write one trace entry
trace_wr_addr  in  PTR_W  trace RAM write index
trace_wr_data  in  ADDR_W  memory reference to store
addr_out  out  ADDR_W  reference presented to cache addr_in
state_out  out  1  phase presented to cache state
hit_in  in  1  hit output from cache
busy  out  1  replay in progress
done  out  1  replay complete; held until next accepted start or rst
hit_count  out  CNT_W  references that returned hit
miss_count  out  CNT_W  references that returned no hit
ref_count  out  CNT_W  references issued
miss_run_max  out  CNT_W  longest run of consecutive misses (see Optional Feature)

Behaviour:
- Reset (asynchronous, any time, including mid-replay):
  - FSM goes to IDLE.
  - addr_out, state_out, busy, done, all counters and miss_run_max go to 0.
  - Trace RAM contents are not cleared.
- FSM states: IDLE, FETCH, READ, WRITE, FINISH.
- IDLE:
  - state_out = 0.
  - start=1 captures len = min(trace_len, TRACE_DEPTH), clears all counters, ptr = 0, done = 0.
  - If len = 0: go to FINISH. Otherwise go to FETCH with busy = 1.
- FETCH (1 cycle): registered RAM read of entry ptr. state_out = 0.
- READ (1 cycle):
  - addr_out = entry; state_out = 0.
  - The cache clears hit and enables the indexed set on this phase.
- WRITE (SETTLE_CYCLES cycles): state_out = 1; addr_out is held stable.
- On the rising edge that ends the last WRITE cycle:
  - Sample hit_in. Increment ref_count, and increment hit_count if hit_in=1, otherwise miss_count.
  - ptr += 1. If ptr == len, go to FINISH; otherwise go to FETCH.
- Cost per reference: 2 + SETTLE_CYCLES cycles. Invariant: hit_count + miss_count == ref_count.
- FINISH (1 cycle): busy = 0, done = 1, state_out = 0; return to IDLE. done stays 1 while in IDLE.
- start while busy: ignored.
- start in IDLE with done=1: accepted; counters are cleared and replay restarts.
- trace_wr_en while busy: ignored, and the RAM is unchanged. trace_wr_en and start in the same IDLE cycle: the write completes; the replay reads the new data.
- Counters saturate at all-ones and never wrap. ref_count saturation also freezes the hit and miss counters, so the invariant holds.
- ptr wraps to 0 only when len = TRACE_DEPTH, after the final entry.
- addr_out holds its last value in IDLE.

Optional Feature:
CACHE_DRV_MISS_RUN_EN:
- Defined: a run counter increments on each sampled miss and clears on each sampled hit. miss_run_max = max(miss_run_max, run) is updated at each sample; both saturate. Both are cleared on accepted start and on rst.
- Undefined: no run logic is built; miss_run_max is tied to 0.

Decomposition:
- Shared package cache_sim_pkg holds:
  - the FSM state enum;
  - the cache address field constants (OFFSET_LSB=0, INDEX_LSB=1, INDEX_W=4, TAG_LSB=5);
  - the phase constants PHASE_READ=0, PHASE_WRITE=1.
- One natural sub-module: trace_ram, a single-port synchronous-write, registered-read RAM of TRACE_DEPTH x ADDR_W.

Test Plan:
1. Load [0x00000040, 0x00000040], len=2, start → ref_count=2, miss_count=1, hit_count=1, done=1 after 2*(2+SETTLE_CYCLES)+2 cycles from start.
2. len=0, start → done=1 two cycles later; all counters 0; state_out never 1.
3. 8 distinct tags to index 3, len=8 → miss_count=8, hit_count=0, miss_run_max=8 with CACHE_DRV_MISS_RUN_EN defined, 0 without.
4. Assert rst during the WRITE phase of entry 5 of 10 → all outputs 0 immediately; a new start replays from entry 0 and ref_count ends at 10.
5. Pulse start and trace_wr_en mid-replay → no restart and RAM unchanged (verified by a second replay); final counts match the original trace.
6. trace_len=TRACE_DEPTH+5 → exactly TRACE_DEPTH references issued, then done.
